// File: rtl/lsu_pkg.sv
// lsu_pkg: access-size encodings, bus direction codes, FSM state type and strobe-mask helper for the load/store unit
package lsu_pkg;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;
  localparam logic MEM_READ = 1'b0;
  localparam logic MEM_WRITE = 1'b1;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_t;
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    return size == SZ_B ? 8'h01 : size == SZ_H ? 8'h03 : size == SZ_W ? 8'h0F : 8'hFF;
  endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane strobe, store lane shift, load extract/extend and misalignment check
//   size/sign/off : access size, zero-extend flag (1) and byte offset within the doubleword
//   wdata         : right-aligned store data;  st_data : store data placed in its byte lanes
//   bus_rdata     : raw doubleword from the bus; ld_data : extracted and extended load value
//   strb          : byte-write strobes (lanes past byte 7 dropped); misalign : natural-alignment violation
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [1:0]      size,
  input  logic            sign,
  input  logic [2:0]      off,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] bus_rdata,
  output logic [7:0]      strb,
  output logic [XLEN-1:0] st_data,
  output logic [XLEN-1:0] ld_data,
  output logic            misalign
);
  logic [XLEN-1:0] sh;
  logic ext;
  assign st_data = wdata << {off, 3'b000};
  assign strb = size_mask(size) << off;
  // right shift zero-fills, so a misaligned load sees zeros above byte 7 before extension
  assign sh = bus_rdata >> {off, 3'b000};
  assign ext = ~sign;
  always_comb begin
    ld_data = size == SZ_B ? {{(XLEN-8){ext & sh[7]}}, sh[7:0]} :
              size == SZ_H ? {{(XLEN-16){ext & sh[15]}}, sh[15:0]} :
              size == SZ_W ? {{(XLEN-32){ext & sh[31]}}, sh[31:0]} : sh;
    misalign = size == SZ_H ? off[0] : size == SZ_W ? |off[1:0] : size == SZ_D ? |off : 1'b0;
  end
endmodule

// File: rtl/lsu.sv
// lsu: load/store unit issuing one aligned 64-bit bus transaction per memory instruction
//   pipeline side : req_valid/req_ready, memrw/memword/memsign, addr, wdata -> stall, done, rdata, fault
//   bus side      : bus_valid/bus_ready request handshake with bus_we/addr/wdata/strb, bus_rvalid/bus_rdata response
//   LSU_MISALIGN_TRAP_EN : when defined, misaligned accesses complete at once with fault and no bus traffic
module lsu
  import lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            memrw,
  input  logic [1:0]      memword,
  input  logic            memsign,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] rdata,
  output logic            fault,
  output logic            bus_valid,
  input  logic            bus_ready,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [XLEN-1:0] bus_wdata,
  output logic [7:0]      bus_strb,
  input  logic            bus_rvalid,
  input  logic [XLEN-1:0] bus_rdata
);
`ifdef LSU_MISALIGN_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif
  lsu_state_t state, next;
  logic op_rw, op_sign, flt_q, idle, accept, trap, misalign;
  logic [1:0] op_size;
  logic [XLEN-1:0] op_addr, op_wdata, ld_q, st_data, ld_data;
  logic [7:0] strb;
  assign idle = state == IDLE;
  assign accept = idle && req_valid;
  assign trap = TRAP_EN && misalign;
  // in IDLE the checker looks at the live request so a trap can be decided on the accept edge
  lsu_align #(.XLEN(XLEN)) u_align (
    .size     (idle ? memword : op_size),
    .sign     (op_sign),
    .off      (idle ? addr[2:0] : op_addr[2:0]),
    .wdata    (op_wdata),
    .bus_rdata(bus_rdata),
    .strb     (strb),
    .st_data  (st_data),
    .ld_data  (ld_data),
    .misalign (misalign)
  );
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE: if (req_valid) next = trap ? DONE : REQ;
      REQ: if (bus_ready) next = WAIT;
      WAIT: if (bus_rvalid) next = DONE;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      op_rw <= MEM_READ;
      op_size <= SZ_B;
      op_sign <= 1'b0;
      op_addr <= '0;
      op_wdata <= '0;
      ld_q <= '0;
      flt_q <= 1'b0;
    end else if (accept) begin
      op_rw <= memrw;
      op_size <= memword;
      op_sign <= memsign;
      op_addr <= addr;
      op_wdata <= wdata;
      ld_q <= '0;
      flt_q <= trap;
    end else if (state == WAIT && bus_rvalid) begin
      ld_q <= op_rw == MEM_READ ? ld_data : '0;
    end
  assign req_ready = idle;
  assign stall = state == REQ || state == WAIT || accept;
  assign done = state == DONE;
  assign rdata = ld_q;
  assign fault = TRAP_EN && done && flt_q;
  assign bus_valid = state == REQ;
  assign bus_we = bus_valid && op_rw == MEM_WRITE;
  assign bus_addr = bus_valid ? {op_addr[XLEN-1:3], 3'b000} : '0;
  assign bus_wdata = bus_valid ? st_data : '0;
  assign bus_strb = bus_we ? strb : 8'h00;
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed self-checking bench for lsu with a cycle-stepped bus responder
module tb_lsu;
  import lsu_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b0;
  logic req_ready;
  logic memrw = 1'b0;
  logic [1:0] memword = SZ_B;
  logic memsign = 1'b0;
  logic [63:0] addr = '0;
  logic [63:0] wdata = '0;
  logic stall, done, fault, bus_valid, bus_we;
  logic [63:0] rdata, bus_addr, bus_wdata;
  logic [7:0] bus_strb;
  logic bus_ready = 1'b0;
  logic bus_rvalid = 1'b0;
  logic [63:0] bus_rdata = '0;
  int checks = 0;
  int failures = 0;
  logic [63:0] o_rdata, o_addr, o_wdata;
  logic [7:0] o_strb;
  logic o_fault, o_we, o_stable, o_stall, o_seen;
  int o_lat, o_dones, o_vcyc;
  always #5 clk = ~clk;
  lsu dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .memrw(memrw), .memword(memword), .memsign(memsign), .addr(addr), .wdata(wdata),
    .stall(stall), .done(done), .rdata(rdata), .fault(fault),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_strb(bus_strb), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // issue one request; the bus holds bus_ready low for rdly REQ cycles and bus_rvalid low for vdly WAIT cycles
  task automatic go(input logic rw, input logic [1:0] sz, input logic sg, input logic [63:0] a,
                    input logic [63:0] wd, input logic [63:0] rd, input int rdly, input int vdly,
                    input logic early);
    int vc = 0;
    int wc = 0;
    memrw = rw; memword = sz; memsign = sg; addr = a; wdata = wd; bus_rdata = rd;
    bus_ready = 1'b0; bus_rvalid = 1'b0; req_valid = 1'b1;
    o_lat = -1; o_dones = 0; o_seen = 1'b0; o_stable = 1'b1; o_vcyc = 0;
    o_rdata = 'x; o_fault = 'x; o_addr = '0; o_wdata = '0; o_strb = '0; o_we = 1'b0;
    #1 o_stall = stall;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (done) begin
        o_lat = c; o_dones = 1; o_rdata = rdata; o_fault = fault;
        break;
      end
      if (!stall) o_stall = 1'b0;
      if (bus_valid) begin
        if (!o_seen) begin
          o_seen = 1'b1; o_addr = bus_addr; o_wdata = bus_wdata; o_strb = bus_strb; o_we = bus_we;
        end else if ({bus_addr, bus_wdata, bus_strb, bus_we} !== {o_addr, o_wdata, o_strb, o_we}) o_stable = 1'b0;
        o_vcyc++;
        bus_ready = vc >= rdly;
        bus_rvalid = early;
        vc++;
      end else begin
        bus_ready = 1'b0;
        bus_rvalid = o_seen && wc >= vdly;
        if (o_seen) wc++;
      end
    end
    req_valid = 1'b0; bus_ready = 1'b0; bus_rvalid = 1'b0;
    tick();
    if (done) o_dones++;
    check("ready_after", req_ready, 1);
  endtask
  initial begin
    tick();
    tick();
    check("rst_ready", req_ready, 1);
    check("rst_outs", {stall, done, fault, bus_valid, bus_we, bus_strb}, 0);
    check("rst_bus", bus_addr | bus_wdata | rdata, 0);
    rst_n = 1'b1;
    tick();
    // signed byte load, byte 5 = 0x80
    go(MEM_READ, SZ_B, 1'b0, 64'h1005, 64'h0, 64'h0000_8000_0000_0000, 0, 0, 1'b0);
    check("lb_addr", o_addr, 64'h1000);
    check("lb_strb", o_strb, 0);
    check("lb_we", o_we, 0);
    check("lb_lat", o_lat, 3);
    check("lb_rdata", o_rdata, 64'hFFFF_FFFF_FFFF_FF80);
    check("lb_stall", o_stall, 1);
    check("lb_fault", o_fault, 0);
    go(MEM_READ, SZ_H, 1'b1, 64'h2006, 64'h0, 64'h8001_0000_0000_0000, 0, 0, 1'b0);
    check("lhu_rdata", o_rdata, 64'h8001);
    go(MEM_READ, SZ_H, 1'b0, 64'h2006, 64'h0, 64'h8001_0000_0000_0000, 0, 0, 1'b0);
    check("lh_rdata", o_rdata, 64'hFFFF_FFFF_FFFF_8001);
    go(MEM_WRITE, SZ_W, 1'b0, 64'h3004, 64'hDEAD_BEEF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 1'b0);
    check("sw_we", o_we, 1);
    check("sw_strb", o_strb, 8'hF0);
    check("sw_wdata", o_wdata, 64'hDEAD_BEEF_0000_0000);
    check("sw_addr", o_addr, 64'h3000);
    check("sw_rdata", o_rdata, 0);
    go(MEM_READ, SZ_W, 1'b0, 64'h6004, 64'h0, 64'h8000_0001_0000_0000, 0, 0, 1'b0);
    check("lw_rdata", o_rdata, 64'hFFFF_FFFF_8000_0001);
    go(MEM_READ, SZ_B, 1'b1, 64'h9000, 64'h0, 64'h1234_5678_9ABC_DEFE, 0, 0, 1'b0);
    check("lbu_rdata", o_rdata, 64'hFE);
    // bus_ready low 4 cycles, bus_rvalid 3 cycles late
    go(MEM_READ, SZ_D, 1'b1, 64'h5000, 64'h0, 64'h0123_4567_89AB_CDEF, 4, 3, 1'b0);
    check("slow_stable", o_stable, 1);
    check("slow_stall", o_stall, 1);
    check("slow_vcyc", o_vcyc, 5);
    check("slow_lat", o_lat, 10);
    check("slow_dones", o_dones, 1);
    check("slow_rdata", o_rdata, 64'h0123_4567_89AB_CDEF);
    // bus_rvalid during the REQ handshake must not complete the access
    go(MEM_READ, SZ_B, 1'b0, 64'hA003, 64'h0, 64'h0000_0000_7F00_0000, 0, 2, 1'b1);
    check("early_lat", o_lat, 5);
    check("early_rdata", o_rdata, 64'h7F);
`ifdef LSU_MISALIGN_TRAP_EN
    go(MEM_READ, SZ_D, 1'b0, 64'h4004, 64'h0, 64'hAABB_CCDD_1122_3344, 0, 0, 1'b0);
    check("ld_mis_lat", o_lat, 1);
    check("ld_mis_fault", o_fault, 1);
    check("ld_mis_bus", o_seen, 0);
    check("ld_mis_rdata", o_rdata, 0);
    go(MEM_WRITE, SZ_H, 1'b0, 64'h8007, 64'hBEEF, 64'h0, 0, 0, 1'b0);
    check("sh_mis_fault", o_fault, 1);
    check("sh_mis_bus", o_seen, 0);
`else
    go(MEM_READ, SZ_D, 1'b0, 64'h4004, 64'h0, 64'hAABB_CCDD_1122_3344, 0, 0, 1'b0);
    check("ld_mis_lat", o_lat, 3);
    check("ld_mis_fault", o_fault, 0);
    check("ld_mis_addr", o_addr, 64'h4000);
    check("ld_mis_rdata", o_rdata, 64'hAABB_CCDD);
    go(MEM_WRITE, SZ_H, 1'b0, 64'h8007, 64'hBEEF, 64'h0, 0, 0, 1'b0);
    check("sh_mis_strb", o_strb, 8'h80);
    check("sh_mis_wdata", o_wdata, 64'hEF00_0000_0000_0000);
    go(MEM_READ, SZ_W, 1'b0, 64'hB006, 64'h0, 64'hCAFE_0000_0000_0000, 0, 0, 1'b0);
    check("lw_mis_rdata", o_rdata, 64'hCAFE);
`endif
    // reset during WAIT, then a late bus_rvalid
    memrw = MEM_READ; memword = SZ_D; memsign = 1'b0; addr = 64'h7000; bus_rdata = 64'h55;
    req_valid = 1'b1; bus_ready = 1'b1; bus_rvalid = 1'b0;
    tick();
    check("rw_req_valid", bus_valid, 1);
    tick();
    check("rw_wait", {bus_valid, stall}, 2'b01);
    rst_n = 1'b0; req_valid = 1'b0; bus_ready = 1'b0;
    tick();
    check("rw_idle", {req_ready, bus_valid, done, stall}, 4'b1000);
    rst_n = 1'b1; bus_rvalid = 1'b1;
    tick();
    bus_rvalid = 1'b0;
    check("rw_late", {req_ready, done, bus_valid}, 3'b100);
    check("rw_rdata", rdata, 0);
    tick();
    check("rw_nodone", done, 0);
    // reset during REQ
    req_valid = 1'b1;
    tick();
    check("rr_req", bus_valid, 1);
    rst_n = 1'b0; req_valid = 1'b0;
    tick();
    check("rr_idle", {req_ready, bus_valid, done}, 3'b100);
    rst_n = 1'b1;
    tick();
    check("rr_nodone", done, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lsu.md
# lsu

Load/store unit directly downstream of the control unit in the RV64 datapath. Takes the control unit's `memrw`/`memword`/`memsign` decode plus the ALU address and rs2 data, and performs one aligned 64-bit bus transaction per memory instruction. Stores drive byte-lane strobes; loads extract and sign- or zero-extend the selected lanes. The pipeline is stalled until the access completes.

## Interface
- `XLEN`, 64: data and address width; the only supported value.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `req_valid`  in  1  a memory instruction is presented; the operands below are held stable until `done`.
- `req_ready`  out  1  high only in IDLE.
- `memrw`  in  1  0 = read (load), 1 = write (store).
- `memword`  in  2  access size: 00 byte, 01 half, 10 word, 11 double.
- `memsign`  in  1  0 = sign-extend the load, 1 = zero-extend (funct3[2]).
- `addr`  in  64  byte address from the ALU.
- `wdata`  in  64  store data (rs2), right-aligned.
- `stall`  out  1  freeze the upstream pipeline.
- `done`  out  1  one-cycle completion pulse.
- `rdata`  out  64  extended load result; valid while `done`=1.
- `fault`  out  1  misaligned-access fault, qualified by `done`.
- `bus_valid`  out  1  bus request valid.
- `bus_ready`  in  1  bus accepts the request.
- `bus_we`  out  1  write request.
- `bus_addr`  out  64  address of the 8-byte-aligned doubleword (`addr[2:0]` forced to 0).
- `bus_wdata`  out  64  store data shifted into its byte lanes.
- `bus_strb`  out  8  byte-write strobes; 0 for reads.
- `bus_rvalid`  in  1  response or store acknowledge.
- `bus_rdata`  in  64  read data.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - On `req_valid`, latch `memrw`, `memword`, `memsign`, `addr` and `wdata`, then go to REQ.
  - With `LSU_MISALIGN_TRAP_EN` defined and the access misaligned, go to DONE instead, with fault set.
- REQ:
  - `bus_valid`=1, with all bus outputs driven from the latched operands.
  - Hold until `bus_ready`=1, then go to WAIT.
- WAIT:
  - Hold until `bus_rvalid`=1.
  - Latch the extended `bus_rdata` (loads) and go to DONE.
  - Stores also wait for `bus_rvalid` as their acknowledge; `bus_rdata` is ignored for stores.
- DONE: `done`=1 for one cycle, then go to IDLE. A new request is accepted next cycle at the earliest.
- Lane rules, with off = `addr[2:0]`:
  - `bus_wdata` = `wdata` << (8·off).
  - `bus_strb` = {01, 03, 0F, FF}[`memword`] << off, truncated to 8 bits.
  - Load: shift `bus_rdata` right by 8·off, take 8/16/32/64 bits, then extend per `memsign`.
  - Double loads ignore `memsign`.
  - Stores: `rdata`=0.
- `stall` = (state ∈ {REQ, WAIT}) or (state = IDLE and `req_valid`).
- `bus_rvalid` outside WAIT is ignored.

## Timing
- Reset values: state IDLE; `req_ready`=1; all other outputs 0.
- Minimum latency is accept edge to `done` = 3 cycles (`bus_ready` and `bus_rvalid` both immediate):
  - cycle 0: IDLE accept;
  - cycle 1: REQ handshake;
  - cycle 2: WAIT with `bus_rvalid`;
  - cycle 3: DONE.
- `bus_valid` never drops before `bus_ready`. Bus outputs are constant while `bus_valid`=1.
- A `bus_rvalid` arriving in the same cycle as the REQ handshake is not captured. The bus returns its response no earlier than the cycle after acceptance.
- Misaligned trap path: accept to `done` = 1 cycle, with no bus activity.
- Reset during REQ or WAIT:
  - The next state is IDLE and `bus_valid` is 0 from that edge.
  - A late `bus_rvalid` is ignored.
  - `done` is not pulsed.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - Misaligned means half with `addr[0]`≠0, word with `addr[1:0]`≠0, or double with `addr[2:0]`≠0.
  - A misaligned access produces `fault`=1 with `done`, `rdata`=0, and no bus transaction.
- Undefined:
  - `fault` is tied 0.
  - A misaligned access proceeds; lanes beyond byte 7 are discarded (strobe truncated, load zero-filled above the doubleword before extension).

## Structure
- `lsu_pkg`: size encodings (`SZ_B`/`SZ_H`/`SZ_W`/`SZ_D`), `MEM_READ`=0, `MEM_WRITE`=1, and the FSM state enum.
- Sub-module `lsu_align`: purely combinational strobe generation, write-lane shift, read-lane extract/extend and misalignment check. `lsu` holds the FSM and registers.

## Test plan
- Signed byte load, `addr`=0x1005, `bus_rdata`=0x00_80_00..00 (byte 5 = 0x80), ready/rvalid immediate → `bus_addr`=0x1000, `bus_strb`=0, `done` at cycle 3, `rdata`=0xFFFF_FFFF_FFFF_FF80.
- LHU with `addr`=0x2006 and `bus_rdata`[63:48]=0x8001 → `rdata`=0x0000_0000_0000_8001.
- SW with `addr`=0x3004 and `wdata`=0xDEADBEEF → `bus_we`=1, `bus_strb`=0xF0, `bus_wdata`[63:32]=0xDEADBEEF, `rdata`=0.
- `bus_ready` held low for 4 cycles, then `bus_rvalid` delayed 3 cycles → `bus_valid` and its outputs stay stable, `stall`=1 throughout, a single `done` pulse.
- LD with `addr`=0x4004:
  - with `LSU_MISALIGN_TRAP_EN`: `done`+`fault` at cycle 1 and `bus_valid` never asserted;
  - without it: the bus read proceeds, `fault`=0.
- `rst_n`=0 asserted during WAIT, then `bus_rvalid` pulses → state IDLE, no `done`, `req_ready`=1.
